// File: rtl/pipeline_serializer_counter.sv
// Loadable down-counter with synchronous clear; decrement saturates at zero.
// Intended for block-drain bookkeeping where a load may coincide with the last decrement.
module pipeline_serializer_counter #(
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_load,
    input  logic [COUNT_WIDTH-1:0] i_load_value,
    input  logic                   i_decrement,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [COUNT_WIDTH-1:0] r_count;

    // Count register: clear beats load, load beats decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= {COUNT_WIDTH{1'b0}};
        end else if (i_clear) begin
            r_count <= {COUNT_WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_decrement && (r_count != {COUNT_WIDTH{1'b0}})) begin
            r_count <= r_count - COUNT_WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_serializer.sv
// Parallel-in, serial-out word shifter with valid/ready on both sides.
// A block of WORD_COUNT words is loaded at once and emitted lowest index first.
module pipeline_serializer #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [WORD_WIDTH*WORD_COUNT-1:0] parallel_in,
    input  logic                             parallel_in_valid,
    output logic                             parallel_in_ready,
    output logic [WORD_WIDTH-1:0]            serial_out,
    output logic                             serial_out_valid,
    input  logic                             serial_out_ready
);

    localparam int COUNT_WIDTH = $clog2(WORD_COUNT + 1);
    localparam int BLOCK_WIDTH = WORD_WIDTH * WORD_COUNT;

    logic [BLOCK_WIDTH-1:0] r_shift;
    logic [COUNT_WIDTH-1:0] w_remaining;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_in_ready;

    assign w_in_hs  = parallel_in_valid & w_in_ready;
    assign w_out_hs = serial_out_valid & serial_out_ready;

    // Ready is combinational on serial_out_ready so the last word and the next load share a cycle.
    always_comb begin
        w_in_ready = 1'b0;
        if (w_remaining == {COUNT_WIDTH{1'b0}}) begin
            w_in_ready = 1'b1;
        end else if (w_remaining == COUNT_WIDTH'(1)) begin
            w_in_ready = serial_out_ready;
        end else begin
            w_in_ready = 1'b0;
        end
    end

    // Word storage: a load overrides the shift that would retire the final word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= {BLOCK_WIDTH{1'b0}};
        end else if (clear) begin
            r_shift <= {BLOCK_WIDTH{1'b0}};
        end else if (w_in_hs) begin
            r_shift <= parallel_in;
        end else if (w_out_hs) begin
            r_shift <= r_shift >> WORD_WIDTH;
        end else begin
            r_shift <= r_shift;
        end
    end

    pipeline_serializer_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (clear),
        .i_load       (w_in_hs),
        .i_load_value (COUNT_WIDTH'(WORD_COUNT)),
        .i_decrement  (w_out_hs),
        .o_count      (w_remaining)
    );

    assign parallel_in_ready = w_in_ready;
    assign serial_out        = r_shift[WORD_WIDTH-1:0];
    assign serial_out_valid  = (w_remaining != {COUNT_WIDTH{1'b0}});

endmodule

// File: tb/tb_pipeline_serializer.sv
// Directed self-checking bench for pipeline_serializer (WORD_WIDTH=8, WORD_COUNT=4).
module tb_pipeline_serializer;

    logic        clock;
    logic        reset;
    logic        clear;
    logic [31:0] parallel_in;
    logic        parallel_in_valid;
    logic        parallel_in_ready;
    logic [7:0]  serial_out;
    logic        serial_out_valid;
    logic        serial_out_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] blk_a;
    logic [31:0] blk_b;
    logic [7:0]  exp_a [4];
    logic [7:0]  exp_b [4];

    pipeline_serializer #(
        .WORD_WIDTH (8),
        .WORD_COUNT (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .clear             (clear),
        .parallel_in       (parallel_in),
        .parallel_in_valid (parallel_in_valid),
        .parallel_in_ready (parallel_in_ready),
        .serial_out        (serial_out),
        .serial_out_valid  (serial_out_valid),
        .serial_out_ready  (serial_out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, then let combinational outputs settle.
    task automatic cyc(input logic piv, input logic [31:0] pin, input logic sor, input logic clr);
        @(negedge clock);
        parallel_in_valid = piv;
        parallel_in       = pin;
        serial_out_ready  = sor;
        clear             = clr;
        #1;
    endtask

    initial begin
        blk_a = 32'h44332211;
        blk_b = 32'h88776655;
        exp_a[0] = 8'h11; exp_a[1] = 8'h22; exp_a[2] = 8'h33; exp_a[3] = 8'h44;
        exp_b[0] = 8'h55; exp_b[1] = 8'h66; exp_b[2] = 8'h77; exp_b[3] = 8'h88;

        reset = 1'b1; clear = 1'b0; parallel_in = 32'h0;
        parallel_in_valid = 1'b0; serial_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_valid", 32'(serial_out_valid), 32'h0);
        chk("rst_ready", 32'(parallel_in_ready), 32'h1);
        chk("rst_data",  32'(serial_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single block, consumer always ready
        cyc(1'b1, blk_a, 1'b1, 1'b0);
        chk("t1_ready_idle", 32'(parallel_in_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t1_data",  32'(serial_out), 32'(exp_a[i]));
            chk("t1_valid", 32'(serial_out_valid), 32'h1);
            chk("t1_ready", 32'(parallel_in_ready), (i == 3) ? 32'h1 : 32'h0);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_done_valid", 32'(serial_out_valid), 32'h0);
        chk("t1_done_ready", 32'(parallel_in_ready), 32'h1);
        chk("t1_done_data",  32'(serial_out), 32'h0);

        // Back-to-back blocks with valid held
        cyc(1'b1, blk_a, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, blk_b, 1'b1, 1'b0);
            chk("t2_data_a",  32'(serial_out), 32'(exp_a[i]));
            chk("t2_valid_a", 32'(serial_out_valid), 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t2_data_b",  32'(serial_out), 32'(exp_b[i]));
            chk("t2_valid_b", 32'(serial_out_valid), 32'h1);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_done_valid", 32'(serial_out_valid), 32'h0);

        // Consumer stalls three cycles while 0x22 is showing
        cyc(1'b1, blk_a, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t3_first", 32'(serial_out), 32'h11);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0);
            chk("t3_stall_data",  32'(serial_out), 32'h22);
            chk("t3_stall_valid", 32'(serial_out_valid), 32'h1);
            chk("t3_stall_ready", 32'(parallel_in_ready), 32'h0);
            chk("t3_stall_rem",   32'(dut.w_remaining), 32'h3);
        end
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t3_drain", 32'(serial_out), 32'(exp_a[i]));
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t3_done_valid", 32'(serial_out_valid), 32'h0);

        // clear while 0x33 shows, with a block offered in the same cycle
        cyc(1'b1, blk_a, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_w0", 32'(serial_out), 32'h11);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_w1", 32'(serial_out), 32'h22);
        cyc(1'b1, blk_b, 1'b1, 1'b1);
        chk("t4_w2", 32'(serial_out), 32'h33);
        cyc(1'b1, blk_b, 1'b1, 1'b0);
        chk("t4_clr_valid", 32'(serial_out_valid), 32'h0);
        chk("t4_clr_ready", 32'(parallel_in_ready), 32'h1);
        chk("t4_clr_data",  32'(serial_out), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t4_new", 32'(serial_out), 32'(exp_b[i]));
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_done_valid", 32'(serial_out_valid), 32'h0);

        // Asynchronous reset in the middle of a drain
        cyc(1'b1, blk_a, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_w0", 32'(serial_out), 32'h11);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_w1", 32'(serial_out), 32'h22);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_valid", 32'(serial_out_valid), 32'h0);
        chk("t5_async_data",  32'(serial_out), 32'h0);
        chk("t5_async_ready", 32'(parallel_in_ready), 32'h1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t5_post_valid", 32'(serial_out_valid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
